decode_unit: RTL and testbench

DECODE_UNIT -- requirements
Module: decode_unit

---
 rtl/rv_decode_pkg.sv | 58 +++++
 rtl/decode_comb.sv | 152 +++++++++++++++
 rtl/decode_unit.sv | 128 ++++++++++++
 tb/tb_decode_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg
//   Shared decode vocabulary: the opclass enumeration delivered to the
//   back end, RV32 major opcodes, SYSTEM funct3 codes, the funct12 codes that
//   identify the privileged SYSTEM instructions, and the immediate format tag
//   used internally by the decoder.
package rv_decode_pkg;

  typedef enum logic [3:0] {
    OC_LUI     = 4'd0,
    OC_AUIPC   = 4'd1,
    OC_JAL     = 4'd2,
    OC_JALR    = 4'd3,
    OC_BRANCH  = 4'd4,
    OC_LOAD    = 4'd5,
    OC_STORE   = 4'd6,
    OC_OPIMM   = 4'd7,
    OC_OP      = 4'd8,
    OC_FENCE   = 4'd9,
    OC_CSR     = 4'd10,
    OC_ECALL   = 4'd11,
    OC_EBREAK  = 4'd12,
    OC_MRET    = 4'd13,
    OC_WFI     = 4'd14,
    OC_ILLEGAL = 4'd15
  } opclass_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // SYSTEM funct3: 0 selects the privileged group, 4 is reserved.
  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_MRET   = 12'h302;
  localparam logic [11:0] F12_WFI    = 12'h105;

  // FMT_Z is the zero-extended 5-bit CSR uimm carried in the rs1 field.
  typedef enum logic [2:0] {
    FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z
  } imm_fmt_e;

endpackage

// File: rtl/decode_comb.sv
// decode_comb
//   Purely combinational RV32 instruction decoder with immediate generation.
//   Ports:
//     instr_i      32-bit instruction word
//     opclass_o    instruction class (rv_decode_pkg::opclass_e encoding)
//     rd_o/rs1_o/rs2_o  register indices, 0 when the format does not use them
//     imm_o        sign-extended immediate (CSR uimm is zero-extended)
//     funct3_o, funct7_b5_o, csr_addr_o  auxiliary fields
//     illegal_o    1 when the word is not a legal instruction; every other
//                  field is then forced to 0
module decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int ENABLE_ZICSR = 1,
  localparam int RW          = $clog2(NREG)
) (
  input  logic [31:0]     instr_i,
  output logic [3:0]      opclass_o,
  output logic [RW-1:0]   rd_o,
  output logic [RW-1:0]   rs1_o,
  output logic [RW-1:0]   rs2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      funct3_o,
  output logic            funct7_b5_o,
  output logic [11:0]     csr_addr_o,
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] f12;
  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign f12    = instr_i[31:20];

  opclass_e  cls;
  imm_fmt_e  fmt;
  logic      ok, use_rd, use_rs1, use_rs2, has_f3, has_f7b5, is_csr;
  logic      reg_bad, legal;
  logic [31:0] imm32;

  always_comb begin
    cls      = OC_ILLEGAL;
    fmt      = FMT_NONE;
    ok       = 1'b0;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    has_f3   = 1'b0;
    has_f7b5 = 1'b0;
    is_csr   = 1'b0;
    unique case (opcode)
      OPC_LUI:    begin cls = OC_LUI;   ok = 1'b1; use_rd = 1'b1; fmt = FMT_U; end
      OPC_AUIPC:  begin cls = OC_AUIPC; ok = 1'b1; use_rd = 1'b1; fmt = FMT_U; end
      OPC_JAL:    begin cls = OC_JAL;   ok = 1'b1; use_rd = 1'b1; fmt = FMT_J; end
      OPC_JALR: begin
        cls = OC_JALR; ok = (f3 == 3'b000);
        use_rd = 1'b1; use_rs1 = 1'b1; fmt = FMT_I;
      end
      OPC_BRANCH: begin
        cls = OC_BRANCH; ok = (f3 != 3'b010) && (f3 != 3'b011);
        use_rs1 = 1'b1; use_rs2 = 1'b1; has_f3 = 1'b1; fmt = FMT_B;
      end
      OPC_LOAD: begin
        cls = OC_LOAD; ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        use_rd = 1'b1; use_rs1 = 1'b1; has_f3 = 1'b1; fmt = FMT_I;
      end
      OPC_STORE: begin
        cls = OC_STORE; ok = (f3 <= 3'b010);
        use_rs1 = 1'b1; use_rs2 = 1'b1; has_f3 = 1'b1; fmt = FMT_S;
      end
      OPC_OPIMM: begin
        cls = OC_OPIMM;
        // Shift-immediates reuse the funct7 slot; only SRAI may set bit 30.
        if (f3 == 3'b001)      ok = (f7 == 7'h00);
        else if (f3 == 3'b101) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else                   ok = 1'b1;
        has_f7b5 = (f3 == 3'b001) || (f3 == 3'b101);
        use_rd = 1'b1; use_rs1 = 1'b1; has_f3 = 1'b1; fmt = FMT_I;
      end
      OPC_OP: begin
        cls = OC_OP;
        ok  = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        has_f3 = 1'b1; has_f7b5 = 1'b1;
      end
      OPC_FENCE: begin
        cls = OC_FENCE; ok = (f3 == 3'b000);
        use_rd = 1'b1; use_rs1 = 1'b1; has_f3 = 1'b1; fmt = FMT_I;
      end
      OPC_SYSTEM: begin
        if (f3 == F3_PRIV) begin
          // Privileged group: rd and rs1 must both be zero.
          ok = (instr_i[19:15] == 5'd0) && (instr_i[11:7] == 5'd0);
          unique case (f12)
            F12_ECALL:  cls = OC_ECALL;
            F12_EBREAK: cls = OC_EBREAK;
            F12_MRET:   cls = OC_MRET;
            F12_WFI:    cls = OC_WFI;
            default:    ok  = 1'b0;
          endcase
        end else begin
          cls = OC_CSR; is_csr = 1'b1; use_rd = 1'b1; has_f3 = 1'b1;
          ok  = (ENABLE_ZICSR != 0) && (f3 != 3'b100);
          unique case (f3)
            F3_CSRRW, F3_CSRRS, F3_CSRRC:    use_rs1 = 1'b1;
            F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: fmt = FMT_Z;
            default:                         fmt = FMT_NONE;
          endcase
        end
      end
      default: ok = 1'b0;
    endcase
  end

  // RV32E: bit 4 of any register index actually used must be clear.
  assign reg_bad = (NREG < 32) &&
                   ((use_rd  && instr_i[11]) ||
                    (use_rs1 && instr_i[19]) ||
                    (use_rs2 && instr_i[24]));
  assign legal   = ok && !reg_bad;

  always_comb begin
    unique case (fmt)
      FMT_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:   imm32 = {instr_i[31:12], 12'd0};
      FMT_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      FMT_Z:   imm32 = {27'd0, instr_i[19:15]};
      default: imm32 = 32'd0;
    endcase
  end

  assign illegal_o   = !legal;
  assign opclass_o   = legal ? cls : OC_ILLEGAL;
  assign rd_o        = (legal && use_rd)   ? instr_i[7 +: RW]  : '0;
  assign rs1_o       = (legal && use_rs1)  ? instr_i[15 +: RW] : '0;
  assign rs2_o       = (legal && use_rs2)  ? instr_i[20 +: RW] : '0;
  // Size cast of a signed value sign-extends to XLEN (uimm has bit 31 clear).
  assign imm_o       = legal ? XLEN'($signed(imm32)) : '0;
  assign funct3_o    = (legal && has_f3)   ? f3          : 3'd0;
  assign funct7_b5_o = legal && has_f7b5 && instr_i[30];
  assign csr_addr_o  = (legal && is_csr)   ? f12         : 12'd0;

endmodule

// File: rtl/decode_unit.sv
// decode_unit
//   Registered RV32 decode stage: decode_comb feeding a 2-entry in-order
//   skid buffer, plus a free-running delivered-instruction counter.
//   Ports:
//     i_clk, i_rst_n          clock, synchronous active-low reset
//     i_valid/o_ready         upstream handshake (i_instr, i_pc)
//     i_flush                 drop held entries and the current input
//     o_valid/i_ready         downstream handshake carrying the decoded fields
//     o_pc .. o_illegal       decoded fields of the head entry
//     o_dec_count             number of deliveries, wraps at 2^32
module decode_unit
  import rv_decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int ENABLE_ZICSR = 1,
  localparam int RW          = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [3:0]      o_opclass,
  output logic [RW-1:0]   o_rd,
  output logic [RW-1:0]   o_rs1,
  output logic [RW-1:0]   o_rs2,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_funct3,
  output logic            o_funct7_b5,
  output logic [11:0]     o_csr_addr,
  output logic            o_illegal,
  output logic [31:0]     o_dec_count
);

  // One buffer entry holds every output field, packed in port order.
  localparam int EW = 2*XLEN + 4 + 3*RW + 3 + 1 + 12 + 1;

  logic [3:0]      dc_opclass;
  logic [RW-1:0]   dc_rd, dc_rs1, dc_rs2;
  logic [XLEN-1:0] dc_imm;
  logic [2:0]      dc_funct3;
  logic            dc_funct7_b5, dc_illegal;
  logic [11:0]     dc_csr_addr;

  decode_comb #(
    .XLEN         (XLEN),
    .NREG         (NREG),
    .ENABLE_ZICSR (ENABLE_ZICSR)
  ) u_decode_comb (
    .instr_i     (i_instr),
    .opclass_o   (dc_opclass),
    .rd_o        (dc_rd),
    .rs1_o       (dc_rs1),
    .rs2_o       (dc_rs2),
    .imm_o       (dc_imm),
    .funct3_o    (dc_funct3),
    .funct7_b5_o (dc_funct7_b5),
    .csr_addr_o  (dc_csr_addr),
    .illegal_o   (dc_illegal)
  );

  logic [EW-1:0] in_word;
  assign in_word = {i_pc, dc_opclass, dc_rd, dc_rs1, dc_rs2, dc_imm,
                    dc_funct3, dc_funct7_b5, dc_csr_addr, dc_illegal};

  // head_q drives the outputs directly; tail_q is the skid slot.
  logic [EW-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic [31:0]   dec_count_q, dec_count_d;
  logic          accept, deliver;

  assign o_valid = (count_q != 2'd0);
  assign o_ready = (count_q != 2'd2);
  assign accept  = i_valid && o_ready;
  assign deliver = o_valid && i_ready;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    dec_count_d = dec_count_q;
    if (i_flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({accept, deliver})
        2'b10: begin
          if (count_q == 2'd0) head_d = in_word;
          else                 tail_d = in_word;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        // Accepting implies count < 2 and delivering implies count > 0, so
        // the head is the only entry and is replaced in place.
        2'b11:   head_d = in_word;
        default: ;
      endcase
      if (deliver) dec_count_d = dec_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      dec_count_q <= 32'd0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      dec_count_q <= dec_count_d;
    end
  end

  assign {o_pc, o_opclass, o_rd, o_rs1, o_rs2, o_imm,
          o_funct3, o_funct7_b5, o_csr_addr, o_illegal} = head_q;
  assign o_dec_count = dec_count_q;

endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit
//   Two decode_unit instances share one stimulus stream:
//     A: XLEN=32, NREG=32, ENABLE_ZICSR=1
//     B: XLEN=64, NREG=16, ENABLE_ZICSR=0
//   A queue-based reference model tracks the buffer contents and delivery
//   count; a per-instruction decoding function derives the expected fields.
module tb_decode_unit;
  import rv_decode_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        a_ready, a_valid, a_f7, a_ill;
  logic [31:0] a_pc, a_imm, a_count;
  logic [3:0]  a_cls;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3;
  logic [11:0] a_csr;

  logic        b_ready, b_valid, b_f7, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [31:0] b_count;
  logic [3:0]  b_cls;
  logic [3:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_f3;
  logic [11:0] b_csr;

  decode_unit #(.XLEN(32), .NREG(32), .ENABLE_ZICSR(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(a_ready),
    .i_instr(instr), .i_pc(pc[31:0]), .i_flush(flush), .o_valid(a_valid),
    .i_ready(out_ready), .o_pc(a_pc), .o_opclass(a_cls), .o_rd(a_rd),
    .o_rs1(a_rs1), .o_rs2(a_rs2), .o_imm(a_imm), .o_funct3(a_f3),
    .o_funct7_b5(a_f7), .o_csr_addr(a_csr), .o_illegal(a_ill),
    .o_dec_count(a_count)
  );

  decode_unit #(.XLEN(64), .NREG(16), .ENABLE_ZICSR(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(b_ready),
    .i_instr(instr), .i_pc(pc), .i_flush(flush), .o_valid(b_valid),
    .i_ready(out_ready), .o_pc(b_pc), .o_opclass(b_cls), .o_rd(b_rd),
    .o_rs1(b_rs1), .o_rs2(b_rs2), .o_imm(b_imm), .o_funct3(b_f3),
    .o_funct7_b5(b_f7), .o_csr_addr(b_csr), .o_illegal(b_ill),
    .o_dec_count(b_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference decoder ----------------
  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    logic [2:0]  f3;
    logic        f7;
    logic [11:0] csr;
    logic        ill;
  } dec_t;

  function automatic dec_t model_dec(input logic [31:0] i, input bit nreg16, input bit zicsr);
    dec_t d;
    bit ok, ur, u1, u2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    f3 = i[14:12];
    f7 = i[31:25];
    imm_i = {{52{i[31]}}, i[31:20]};
    imm_s = {{52{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {{32{i[31]}}, i[31:12], 12'd0};
    imm_j = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    d = '0; ok = 0; ur = 0; u1 = 0; u2 = 0;
    case (i[6:0])
      7'h37: begin d.cls = OC_LUI;   ok = 1; ur = 1; d.imm = imm_u; end
      7'h17: begin d.cls = OC_AUIPC; ok = 1; ur = 1; d.imm = imm_u; end
      7'h6F: begin d.cls = OC_JAL;   ok = 1; ur = 1; d.imm = imm_j; end
      7'h67: begin d.cls = OC_JALR;  ok = (f3 == 0); ur = 1; u1 = 1; d.imm = imm_i; end
      7'h63: begin
        d.cls = OC_BRANCH; ok = (f3 != 2 && f3 != 3); u1 = 1; u2 = 1; d.imm = imm_b; d.f3 = f3;
      end
      7'h03: begin
        d.cls = OC_LOAD; ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        ur = 1; u1 = 1; d.imm = imm_i; d.f3 = f3;
      end
      7'h23: begin d.cls = OC_STORE; ok = (f3 <= 2); u1 = 1; u2 = 1; d.imm = imm_s; d.f3 = f3; end
      7'h13: begin
        d.cls = OC_OPIMM; ur = 1; u1 = 1; d.imm = imm_i; d.f3 = f3;
        if (f3 == 1)      begin ok = (f7 == 0); d.f7 = i[30]; end
        else if (f3 == 5) begin ok = (f7 == 0 || f7 == 7'h20); d.f7 = i[30]; end
        else ok = 1;
      end
      7'h33: begin
        d.cls = OC_OP; ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        ur = 1; u1 = 1; u2 = 1; d.f3 = f3; d.f7 = i[30];
      end
      7'h0F: begin d.cls = OC_FENCE; ok = (f3 == 0); ur = 1; u1 = 1; d.imm = imm_i; end
      7'h73: begin
        if (f3 == 0) begin
          ok = (i[19:7] == 0);
          case (i[31:20])
            12'h000: d.cls = OC_ECALL;
            12'h001: d.cls = OC_EBREAK;
            12'h302: d.cls = OC_MRET;
            12'h105: d.cls = OC_WFI;
            default: ok = 0;
          endcase
        end else if (f3 != 4 && zicsr) begin
          ok = 1; d.cls = OC_CSR; ur = 1; u1 = (f3 < 4);
          d.imm = (f3 > 4) ? {59'd0, i[19:15]} : 64'd0;
          d.csr = i[31:20]; d.f3 = f3;
        end
      end
      default: ok = 0;
    endcase
    if (ur) d.rd  = i[11:7];
    if (u1) d.rs1 = i[19:15];
    if (u2) d.rs2 = i[24:20];
    if (nreg16 && ((ur && i[11]) || (u1 && i[19]) || (u2 && i[24]))) ok = 0;
    if (!ok) begin
      d = '0; d.cls = OC_ILLEGAL; d.ill = 1;
    end
    return d;
  endfunction

  // ---------------- buffer model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } item_t;

  item_t       mq[$];
  logic [31:0] mcnt;
  bit          cmp_en = 0;

  always @(posedge clk) begin : model_upd
    bit dl, ac;
    if (!rst_n) begin
      mq.delete();
      mcnt = 32'd0;
    end else if (flush) begin
      mq.delete();
    end else begin
      dl = (mq.size() > 0) && out_ready;
      ac = in_valid && (mq.size() < 2);
      if (dl) begin
        $display("deliver %0d pc=%h instr=%h", mcnt + 32'd1, mq[0].pc, mq[0].instr);
        void'(mq.pop_front());
        mcnt = mcnt + 32'd1;
      end
      if (ac) mq.push_back('{instr, pc});
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    dec_t ea, eb;
    if (cmp_en) begin
      chk("a_valid", 64'(a_valid), 64'(mq.size() != 0));
      chk("a_ready", 64'(a_ready), 64'(mq.size() < 2));
      chk("a_count", 64'(a_count), 64'(mcnt));
      chk("b_valid", 64'(b_valid), 64'(mq.size() != 0));
      chk("b_ready", 64'(b_ready), 64'(mq.size() < 2));
      chk("b_count", 64'(b_count), 64'(mcnt));
      if (mq.size() != 0) begin
        ea = model_dec(mq[0].instr, 1'b0, 1'b1);
        eb = model_dec(mq[0].instr, 1'b1, 1'b0);
        chk("a_pc",  64'(a_pc),  64'(mq[0].pc[31:0]));
        chk("a_cls", 64'(a_cls), 64'(ea.cls));
        chk("a_rd",  64'(a_rd),  64'(ea.rd));
        chk("a_rs1", 64'(a_rs1), 64'(ea.rs1));
        chk("a_rs2", 64'(a_rs2), 64'(ea.rs2));
        chk("a_imm", 64'(a_imm), 64'(ea.imm[31:0]));
        chk("a_f3",  64'(a_f3),  64'(ea.f3));
        chk("a_f7",  64'(a_f7),  64'(ea.f7));
        chk("a_csr", 64'(a_csr), 64'(ea.csr));
        chk("a_ill", 64'(a_ill), 64'(ea.ill));
        chk("b_pc",  b_pc,       mq[0].pc);
        chk("b_cls", 64'(b_cls), 64'(eb.cls));
        chk("b_rd",  64'(b_rd),  64'(eb.rd[3:0]));
        chk("b_rs1", 64'(b_rs1), 64'(eb.rs1[3:0]));
        chk("b_rs2", 64'(b_rs2), 64'(eb.rs2[3:0]));
        chk("b_imm", b_imm,      eb.imm);
        chk("b_f3",  64'(b_f3),  64'(eb.f3));
        chk("b_f7",  64'(b_f7),  64'(eb.f7));
        chk("b_csr", 64'(b_csr), 64'(eb.csr));
        chk("b_ill", 64'(b_ill), 64'(eb.ill));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input logic [31:0] ins, input logic [63:0] p);
    in_valid = v;
    instr    = ins;
    pc       = p;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs [11];
    int k;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11) begin
      w[6:0] = opcs[k];
      if ($urandom_range(0, 1) == 1) w[31:25] = {1'b0, w[30], 5'd0};
    end else if (k == 11) begin
      case ($urandom_range(0, 3))
        0: w = 32'h00000073;
        1: w = 32'h00100073;
        2: w = 32'h30200073;
        default: w = 32'h10500073;
      endcase
    end
    return w;
  endfunction

  dec_t pm;

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 64'd0);

    // Literal expectations pinning the reference decoder.
    pm = model_dec(32'hFFF00093, 1'b0, 1'b1);
    chk("pin_addi_cls", 64'(pm.cls), 64'(OC_OPIMM));
    chk("pin_addi_imm", pm.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_addi_rd",  64'(pm.rd), 64'd1);
    pm = model_dec(32'h011000B3, 1'b1, 1'b1);
    chk("pin_add16_ill", 64'(pm.ill), 64'd1);
    chk("pin_add16_rs2", 64'(pm.rs2), 64'd0);
    pm = model_dec(32'h011000B3, 1'b0, 1'b1);
    chk("pin_add32_cls", 64'(pm.cls), 64'(OC_OP));
    chk("pin_add32_rs2", 64'(pm.rs2), 64'd17);
    pm = model_dec(32'h300312F3, 1'b0, 1'b1);
    chk("pin_csr_addr", 64'(pm.csr), 64'h300);
    chk("pin_csr_fld", {pm.f3, pm.rd, pm.rs1}, {51'd0, 3'd1, 5'd5, 5'd6});
    pm = model_dec(32'h300312F3, 1'b0, 1'b0);
    chk("pin_csr_noz", 64'(pm.cls), 64'(OC_ILLEGAL));
    pm = model_dec(32'hFE208EE3, 1'b0, 1'b1);
    chk("pin_beq_imm", pm.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    pm = model_dec(32'h008000EF, 1'b0, 1'b1);
    chk("pin_jal_imm", pm.imm, 64'd8);

    // Reset state.
    repeat (2) @(negedge clk);
    cmp_en = 1;
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_ready", 64'(a_ready), 64'd1);
    chk("rst_count", 64'(a_count), 64'd0);
    chk("rst_fields", {a_pc, a_imm}, 64'd0);
    chk("rst_cls", 64'({a_cls, a_rd, a_csr, a_ill}), 64'd0);
    chk("rst_b_imm", b_imm, 64'd0);

    // addi x1,x0,-1 with one-cycle latency.
    rst_n = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 64'h100);
    @(negedge clk);
    chk("addi_valid", 64'(a_valid), 64'd1);
    chk("addi_cls", 64'(a_cls), 64'(OC_OPIMM));
    chk("addi_rd_rs1", 64'({a_rd, a_rs1}), 64'({5'd1, 5'd0}));
    chk("addi_imm", 64'(a_imm), 64'hFFFF_FFFF);
    chk("addi_pc", 64'(a_pc), 64'h100);
    chk("addi_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b0, 32'd0, 64'd0);
    @(negedge clk);
    chk("addi_count", 64'(a_count), 64'd1);

    // Back-pressure: three back-to-back inputs with i_ready low.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100113, 64'h200);
    @(negedge clk);
    drive(1'b1, 32'h00200193, 64'h204);
    @(negedge clk);
    drive(1'b1, 32'h00300213, 64'h208);
    @(negedge clk);
    chk("bp_ready", 64'(a_ready), 64'd0);
    chk("bp_head", 64'(a_rd), 64'd2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_rise", 64'(a_ready), 64'd1);
    chk("bp_second", 64'(a_rd), 64'd3);
    @(negedge clk);
    chk("bp_third", 64'(a_rd), 64'd4);
    drive(1'b0, 32'd0, 64'd0);
    @(negedge clk);
    chk("bp_count", 64'(a_count), 64'd4);

    // Flush while full with a valid input.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100113, 64'h220);
    @(negedge clk);
    drive(1'b1, 32'h00200193, 64'h224);
    @(negedge clk);
    chk("fl_full", 64'(a_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h00300213, 64'h228);
    @(negedge clk);
    chk("fl_valid", 64'(a_valid), 64'd0);
    chk("fl_ready", 64'(a_ready), 64'd1);
    chk("fl_count", 64'(a_count), 64'd4);
    flush = 1'b0;

    // Register-range and CSR cases on both configurations.
    drive(1'b1, 32'h011000B3, 64'h300);
    @(negedge clk);
    chk("add_a_cls", 64'(a_cls), 64'(OC_OP));
    chk("add_a_rs2", 64'(a_rs2), 64'd17);
    chk("add_b_ill", 64'({b_ill, b_cls, b_rs2}), 64'({1'b1, 4'hF, 4'd0}));
    chk("add_b_pc", b_pc, 64'h300);
    drive(1'b1, 32'h300312F3, 64'h304);
    @(negedge clk);
    chk("csr_a_cls", 64'(a_cls), 64'(OC_CSR));
    chk("csr_a_addr", 64'(a_csr), 64'h300);
    chk("csr_a_fld", 64'({a_f3, a_rd, a_rs1}), 64'({3'd1, 5'd5, 5'd6}));
    chk("csr_b_ill", 64'(b_ill), 64'd1);
    drive(1'b0, 32'd0, 64'd0);
    @(negedge clk);

    // Reset pulse while full overrides handshake and flush.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100113, 64'h400);
    @(negedge clk);
    drive(1'b1, 32'h00200193, 64'h404);
    @(negedge clk);
    chk("rp_full", 64'(a_ready), 64'd0);
    rst_n = 1'b0; out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("rp_valid", 64'(a_valid), 64'd0);
    chk("rp_ready", 64'(a_ready), 64'd1);
    chk("rp_count", 64'(a_count), 64'd0);
    rst_n = 1'b1; flush = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      drive($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom});
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
